memory_stage: RTL and testbench
===============================

MEMORY_STAGE -- requirements
Module: memory_stage

Interface
REQ-001 The module SHALL take parameter DMEM_BYTES, default 1024, data memory size in bytes.
REQ-002 The module SHALL have clock input clk, 1 bit, the sole clock; all state changes occur on its rising edge.
REQ-003 The module SHALL have input rst, 1 bit; reset is synchronous and active-high.
REQ-004 The module SHALL have input M_icode, 4 bits, instruction code held in the memory pipeline register.
REQ-005 The module SHALL have input M_valE, 64 bits, ALU result or computed address.
REQ-006 The module SHALL have input M_valA, 64 bits, store data or stack-pointer address.
REQ-007 The module SHALL have input M_stat, 3 bits, status carried from earlier stages.
REQ-008 The module SHALL have input W_stat, 3 bits, status of the instruction currently in writeback.
REQ-009 The module SHALL have output m_valM, 64 bits, load data for the writeback register.
REQ-010 The module SHALL have output m_stat, 3 bits, status after the memory stage.
REQ-011 The module SHALL have output dmem_error, 1 bit, combinational out-of-range indication for the current access.
REQ-012 The module SHALL have output err_sticky, 1 bit, registered flag set by any dmem_error.
REQ-013 The module SHALL have output store_count, 16 bits, number of committed stores.

Function
REQ-014 Status encodings SHALL be SAOK=1, SHLT=2, SADR=3, SINS=4; icodes SHALL be Y86-64 (RMMOVQ=4, MRMOVQ=5, CALL=8, RET=9, PUSHQ=A, POPQ=B).
REQ-015 mem_addr SHALL be M_valE for RMMOVQ, MRMOVQ, PUSHQ, CALL; M_valA for POPQ, RET; 0 otherwise.
REQ-016 mem_read SHALL be 1 for MRMOVQ, POPQ, RET; mem_write SHALL be 1 for RMMOVQ, PUSHQ, CALL.
REQ-017 dmem_error SHALL be 1 iff (mem_read or mem_write) and mem_addr > DMEM_BYTES-8, as an unsigned 64-bit compare with no wrap-around (address near 2^64-1 is an error).
REQ-018 m_valM SHALL be combinational: little-endian 8-byte read from mem_addr when mem_read and not dmem_error, else 0.
REQ-019 m_stat SHALL be SADR when dmem_error, else M_stat.
REQ-020 A store SHALL commit on a rising clk edge iff mem_write, not dmem_error, M_stat=SAOK, W_stat=SAOK and rst=0; M_valA is written little-endian at mem_addr..mem_addr+7.
REQ-021 Read in the same cycle as a store to the same address SHALL return pre-store contents; the new data is visible from the next cycle.
REQ-022 store_count SHALL increment by 1 on each committed store and wrap 0xFFFF->0x0000.
REQ-023 err_sticky SHALL set on the edge after any cycle with dmem_error=1 and rst=0, and hold until reset.
REQ-024 Any non-memory icode, including invalid codes, SHALL perform no access and pass M_stat unchanged.

Reset
REQ-025 With rst=1 at a rising edge, store_count SHALL become 0, err_sticky SHALL become 0, and no store SHALL commit that cycle.
REQ-026 Data memory contents SHALL NOT be cleared by reset; contents are undefined until written.
REQ-027 Reset asserted mid-sequence SHALL cancel only the store of that cycle; stores committed earlier remain readable after reset.

Verification
REQ-028 RMMOVQ, valE=0x10, valA=0x1122334455667788, both stat SAOK; next cycle MRMOVQ valE=0x10 -> m_valM=0x1122334455667788, store_count=1, m_stat=SAOK.
REQ-029 MRMOVQ valE=DMEM_BYTES-7 -> dmem_error=1, m_stat=SADR, m_valM=0, err_sticky=1 next cycle; valE=DMEM_BYTES-8 -> no error.
REQ-030 PUSHQ valE=0x20 with W_stat=SADR -> no commit, store_count unchanged, later read of 0x20 returns prior value.
REQ-031 POPQ valA=0x10, valE=0x18 after REQ-028 -> reads from 0x10, m_valM=0x1122334455667788.
REQ-032 Store to 0x40 with rst=1 in the same cycle -> store_count=0, 0x40 unchanged; then 65536 committed stores -> store_count wraps to 0.
REQ-033 Back-to-back RMMOVQ then MRMOVQ to 0x8, plus a same-cycle read/write check -> old data in the write cycle, new data the cycle after.

Source files
------------

// File: rtl/memory_stage.sv
// ---------------------------------------------------------------------------
// memory_stage
//   Memory stage of a Y86-64 pipeline. It holds a byte-addressed data
//   memory. Loads are combinational and little-endian, 8 bytes wide.
//   Stores commit on the rising clock edge. The stage also keeps a
//   committed-store counter and a sticky out-of-range error flag.
//
// Parameters
//   DMEM_BYTES   data memory size in bytes
//
// Ports
//   clk          sole clock; all state changes on the rising edge
//   rst          synchronous, active-high reset (clears counter/flag only)
//   M_icode      instruction code in the memory pipeline register
//   M_valE       ALU result / computed address
//   M_valA       store data / stack-pointer address
//   M_stat       status carried from earlier stages
//   W_stat       status of the instruction in writeback
//   m_valM       load data (0 when no valid read)
//   m_stat       status after this stage (SADR on bad address)
//   dmem_error   combinational out-of-range flag for the current access
//   err_sticky   set by any dmem_error, held until reset
//   store_count  number of committed stores, wraps at 16 bits
// ---------------------------------------------------------------------------
module memory_stage #(
    parameter int DMEM_BYTES = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  M_icode,
    input  logic [63:0] M_valE,
    input  logic [63:0] M_valA,
    input  logic [2:0]  M_stat,
    input  logic [2:0]  W_stat,
    output logic [63:0] m_valM,
    output logic [2:0]  m_stat,
    output logic        dmem_error,
    output logic        err_sticky,
    output logic [15:0] store_count
);

    localparam int AW = (DMEM_BYTES > 1) ? $clog2(DMEM_BYTES) : 1;

    // Highest legal base address of an 8-byte access.
    localparam logic [63:0] LAST_BASE = 64'(DMEM_BYTES - 8);

    localparam logic [2:0] SAOK = 3'd1;
    localparam logic [2:0] SADR = 3'd3;

    localparam logic [3:0] I_RMMOVQ = 4'h4;
    localparam logic [3:0] I_MRMOVQ = 4'h5;
    localparam logic [3:0] I_CALL   = 4'h8;
    localparam logic [3:0] I_RET    = 4'h9;
    localparam logic [3:0] I_PUSHQ  = 4'hA;
    localparam logic [3:0] I_POPQ   = 4'hB;

    logic [7:0]    mem_q [DMEM_BYTES];
    logic [15:0]   store_count_q, store_count_d;
    logic          err_sticky_q, err_sticky_d;

    logic [63:0]   mem_addr;
    logic          mem_read;
    logic          mem_write;
    logic [AW-1:0] idx;
    logic          store_en;
    logic [63:0]   rdata;

    // Address and access-type decode.
    always_comb begin
        mem_addr  = 64'd0;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        unique case (M_icode)
            I_RMMOVQ: begin mem_addr = M_valE; mem_write = 1'b1; end
            I_PUSHQ,
            I_CALL:   begin mem_addr = M_valE; mem_write = 1'b1; end
            I_MRMOVQ: begin mem_addr = M_valE; mem_read  = 1'b1; end
            I_POPQ,
            I_RET:    begin mem_addr = M_valA; mem_read  = 1'b1; end
            default:  ;
        endcase
    end

    // A full 64-bit compare, so an address near 2^64-1 is flagged. It is
    // never treated as a small in-range offset.
    assign dmem_error = (mem_read || mem_write) && (mem_addr > LAST_BASE);

    // Only the low bits index the array. They are meaningful only when
    // dmem_error is clear, and every use below is gated on that.
    assign idx = mem_addr[AW-1:0];

    // The load reads the array before this edge's store lands. A
    // same-cycle read therefore sees the old contents.
    always_comb begin
        rdata = 64'd0;
        if (mem_read && !dmem_error) begin
            for (int k = 0; k < 8; k++) begin
                rdata[8*k +: 8] = mem_q[idx + AW'(k)];
            end
        end
    end

    // Younger-instruction stores are squashed if this or the writeback
    // instruction has faulted.
    assign store_en = mem_write && !dmem_error && (M_stat == SAOK) &&
                      (W_stat == SAOK) && !rst;

    always_comb begin
        store_count_d = store_count_q;
        err_sticky_d  = err_sticky_q | dmem_error;
        if (store_en) begin
            store_count_d = store_count_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            store_count_q <= 16'd0;
            err_sticky_q  <= 1'b0;
        end else begin
            store_count_q <= store_count_d;
            err_sticky_q  <= err_sticky_d;
        end
    end

    // Data memory has no reset. Contents survive reset and stay
    // undefined until written.
    always_ff @(posedge clk) begin
        if (store_en) begin
            for (int k = 0; k < 8; k++) begin
                mem_q[idx + AW'(k)] <= M_valA[8*k +: 8];
            end
        end
    end

    assign m_valM      = rdata;
    assign m_stat      = dmem_error ? SADR : M_stat;
    assign err_sticky  = err_sticky_q;
    assign store_count = store_count_q;

endmodule

// File: tb/tb_memory_stage.sv
module tb_memory_stage;

    localparam int DMEM_BYTES = 1024;

    logic        clk;
    logic        rst;
    logic [3:0]  M_icode;
    logic [63:0] M_valE;
    logic [63:0] M_valA;
    logic [2:0]  M_stat;
    logic [2:0]  W_stat;
    logic [63:0] m_valM;
    logic [2:0]  m_stat;
    logic        dmem_error;
    logic        err_sticky;
    logic [15:0] store_count;

    int checks = 0;
    int errors = 0;

    memory_stage #(.DMEM_BYTES(DMEM_BYTES)) dut (
        .clk(clk), .rst(rst), .M_icode(M_icode), .M_valE(M_valE),
        .M_valA(M_valA), .M_stat(M_stat), .W_stat(W_stat),
        .m_valM(m_valM), .m_stat(m_stat), .dmem_error(dmem_error),
        .err_sticky(err_sticky), .store_count(store_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Apply one instruction at the falling edge. Let combinational
    // outputs settle before any checks.
    task automatic apply(input logic [3:0] ic, input logic [63:0] ve,
                         input logic [63:0] va, input logic [2:0] ms,
                         input logic [2:0] ws, input logic r);
        @(negedge clk);
        M_icode = ic; M_valE = ve; M_valA = va; M_stat = ms; W_stat = ws; rst = r;
        #1;
    endtask

    task automatic test_reset;
        apply(4'h1, 64'h0, 64'h0, 3'd1, 3'd1, 1'b1);
        apply(4'h1, 64'h0, 64'h0, 3'd1, 3'd1, 1'b0);
        checks++; if (store_count !== 16'd0) begin errors++; $display("FAIL reset_count got %h exp 0", store_count); end
        checks++; if (err_sticky !== 1'b0) begin errors++; $display("FAIL reset_sticky got %b exp 0", err_sticky); end
        checks++; if (dmem_error !== 1'b0 || m_valM !== 64'd0 || m_stat !== 3'd1) begin
            errors++; $display("FAIL reset_nop got err=%b valM=%h stat=%0d exp 0/0/1", dmem_error, m_valM, m_stat); end
    endtask

    task automatic test_store_load;
        apply(4'h4, 64'h10, 64'h1122334455667788, 3'd1, 3'd1, 1'b0);
        checks++; if (m_valM !== 64'd0 || dmem_error !== 1'b0) begin
            errors++; $display("FAIL store_cycle got valM=%h err=%b exp 0/0", m_valM, dmem_error); end
        apply(4'h5, 64'h10, 64'h0, 3'd1, 3'd1, 1'b0);
        checks++; if (m_valM !== 64'h1122334455667788) begin errors++; $display("FAIL load_0x10 got %h exp 1122334455667788", m_valM); end
        checks++; if (store_count !== 16'd1) begin errors++; $display("FAIL load_count got %0d exp 1", store_count); end
        checks++; if (m_stat !== 3'd1) begin errors++; $display("FAIL load_stat got %0d exp 1", m_stat); end
    endtask

    task automatic test_pop;
        apply(4'h4, 64'h18, 64'h0102030405060708, 3'd1, 3'd1, 1'b0);
        apply(4'hB, 64'h18, 64'h10, 3'd1, 3'd1, 1'b0);
        checks++; if (m_valM !== 64'h1122334455667788) begin errors++; $display("FAIL popq_addr got %h exp 1122334455667788", m_valM); end
        apply(4'h5, 64'h18, 64'h10, 3'd1, 3'd1, 1'b0);
        checks++; if (m_valM !== 64'h0102030405060708) begin errors++; $display("FAIL load_0x18 got %h exp 0102030405060708", m_valM); end
        checks++; if (store_count !== 16'd2) begin errors++; $display("FAIL pop_count got %0d exp 2", store_count); end
    endtask

    task automatic test_bounds;
        apply(4'h5, 64'(DMEM_BYTES - 7), 64'h0, 3'd1, 3'd1, 1'b0);
        checks++; if (dmem_error !== 1'b1 || m_stat !== 3'd3 || m_valM !== 64'd0) begin
            errors++; $display("FAIL oob_read got err=%b stat=%0d valM=%h exp 1/3/0", dmem_error, m_stat, m_valM); end
        checks++; if (err_sticky !== 1'b0) begin errors++; $display("FAIL sticky_early got %b exp 0", err_sticky); end
        apply(4'h5, 64'(DMEM_BYTES - 8), 64'h0, 3'd1, 3'd1, 1'b0);
        checks++; if (err_sticky !== 1'b1) begin errors++; $display("FAIL sticky_set got %b exp 1", err_sticky); end
        checks++; if (dmem_error !== 1'b0 || m_stat !== 3'd1) begin
            errors++; $display("FAIL last_base got err=%b stat=%0d exp 0/1", dmem_error, m_stat); end
        apply(4'h9, 64'h0, 64'hFFFF_FFFF_FFFF_FFF8, 3'd1, 3'd1, 1'b0);
        checks++; if (dmem_error !== 1'b1 || m_stat !== 3'd3) begin
            errors++; $display("FAIL wrap_addr got err=%b stat=%0d exp 1/3", dmem_error, m_stat); end
        apply(4'h4, 64'(DMEM_BYTES - 1), 64'h55, 3'd1, 3'd1, 1'b0);
        checks++; if (dmem_error !== 1'b1) begin errors++; $display("FAIL oob_write got %b exp 1", dmem_error); end
        apply(4'hC, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 3'd4, 3'd1, 1'b0);
        checks++; if (store_count !== 16'd2) begin errors++; $display("FAIL oob_write_count got %0d exp 2", store_count); end
        checks++; if (dmem_error !== 1'b0 || m_stat !== 3'd4 || m_valM !== 64'd0) begin
            errors++; $display("FAIL invalid_icode got err=%b stat=%0d valM=%h exp 0/4/0", dmem_error, m_stat, m_valM); end
    endtask

    task automatic test_wstat;
        apply(4'h4, 64'h20, 64'hCAFE_F00D_1234_5678, 3'd1, 3'd1, 1'b0);
        apply(4'hA, 64'h20, 64'h9999_8888_7777_6666, 3'd1, 3'd3, 1'b0);
        apply(4'h4, 64'h20, 64'h5555_4444_3333_2222, 3'd4, 3'd1, 1'b0);
        checks++; if (m_stat !== 3'd4) begin errors++; $display("FAIL mstat_pass got %0d exp 4", m_stat); end
        apply(4'h5, 64'h20, 64'h0, 3'd1, 3'd1, 1'b0);
        checks++; if (store_count !== 16'd3) begin errors++; $display("FAIL squash_count got %0d exp 3", store_count); end
        checks++; if (m_valM !== 64'hCAFE_F00D_1234_5678) begin errors++; $display("FAIL squash_data got %h exp cafef00d12345678", m_valM); end
    endtask

    task automatic test_back_to_back;
        apply(4'h4, 64'h8, 64'hAAAA_BBBB_CCCC_DDDD, 3'd1, 3'd1, 1'b0);
        apply(4'h5, 64'h8, 64'h0, 3'd1, 3'd1, 1'b0);
        checks++; if (m_valM !== 64'hAAAA_BBBB_CCCC_DDDD) begin errors++; $display("FAIL b2b_old got %h exp aaaabbbbccccdddd", m_valM); end
        apply(4'h4, 64'h8, 64'h0123_4567_89AB_CDEF, 3'd1, 3'd1, 1'b0);
        apply(4'h5, 64'h8, 64'h0, 3'd1, 3'd1, 1'b0);
        checks++; if (m_valM !== 64'h0123_4567_89AB_CDEF) begin errors++; $display("FAIL b2b_new got %h exp 0123456789abcdef", m_valM); end
        checks++; if (store_count !== 16'd5) begin errors++; $display("FAIL b2b_count got %0d exp 5", store_count); end
    endtask

    task automatic test_reset_store;
        apply(4'h4, 64'h40, 64'h7777_0000_7777_0000, 3'd1, 3'd1, 1'b0);
        apply(4'h4, 64'h40, 64'hDEAD_BEEF_DEAD_BEEF, 3'd1, 3'd1, 1'b1);
        apply(4'h5, 64'h40, 64'h0, 3'd1, 3'd1, 1'b0);
        checks++; if (store_count !== 16'd0) begin errors++; $display("FAIL rst_store_count got %0d exp 0", store_count); end
        checks++; if (err_sticky !== 1'b0) begin errors++; $display("FAIL rst_sticky got %b exp 0", err_sticky); end
        checks++; if (m_valM !== 64'h7777_0000_7777_0000) begin errors++; $display("FAIL rst_keep_mem got %h exp 7777000077770000", m_valM); end
        for (int i = 0; i < 65535; i++) begin
            apply(4'h4, 64'h0, 64'(i), 3'd1, 3'd1, 1'b0);
        end
        apply(4'h4, 64'h0, 64'hFFFF, 3'd1, 3'd1, 1'b0);
        checks++; if (store_count !== 16'hFFFF) begin errors++; $display("FAIL count_ffff got %h exp ffff", store_count); end
        apply(4'h5, 64'h0, 64'h0, 3'd1, 3'd1, 1'b0);
        checks++; if (store_count !== 16'h0000) begin errors++; $display("FAIL count_wrap got %h exp 0000", store_count); end
        checks++; if (m_valM !== 64'hFFFF) begin errors++; $display("FAIL last_store got %h exp ffff", m_valM); end
    endtask

    initial begin
        rst = 1'b1; M_icode = 4'h0; M_valE = '0; M_valA = '0; M_stat = 3'd1; W_stat = 3'd1;
        test_reset;
        test_store_load;
        test_pop;
        test_bounds;
        test_wstat;
        test_back_to_back;
        test_reset_store;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
